// File: rtl/pos_cell_stream_reader.sv
// Read-side sequencer for the per-cell position RAM: fetches the particle count, then streams records.
// Optional count clamping is enabled by defining POS_STREAM_COUNT_CLAMP_EN.
module pos_cell_stream_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int SW = $clog2(FIFO_DEPTH + 4) + 1;
  localparam int EW = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CNT_WAIT = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_FIN      = 3'd4;

  if (FIFO_DEPTH < 3 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_cfg_check
    $error("pos_cell_stream_reader: illegal parameter combination");
  end

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rden_q, rden_d;
  logic                  last_q, last_d;
  logic                  last_sent_q, last_sent_d;
  logic [1:0]            infl_q;
  logic [ADDR_WIDTH-1:0] tag0_idx_q, tag1_idx_q;
  logic                  tag0_last_q, tag1_last_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         wp_q, rp_q;
  logic [EW-1:0]         fifo_mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] raw_count, new_count;
  logic [SW-1:0]         credit_sum;
  logic                  can_issue, in_valid, fifo_empty, pop, store, deq;
  logic [EW-1:0]         incoming, out_entry;
  logic [ADDR_WIDTH-1:0] entry_idx;
  logic                  entry_last;

  assign raw_count = mem_q[ADDR_WIDTH-1:0];

`ifdef POS_STREAM_COUNT_CLAMP_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  logic count_over;
  logic err_q, err_d;
  assign count_over = raw_count > MAX_COUNT;
  assign new_count  = count_over ? MAX_COUNT : raw_count;
  assign count_err  = err_q;
`else
  assign new_count  = raw_count;
  assign count_err  = 1'b0;
`endif

  // Every read that could still land in the buffer counts against its depth.
  assign credit_sum = SW'(occ_q) + SW'(rden_q) + SW'(infl_q[0]) + SW'(infl_q[1]);
  assign can_issue  = credit_sum < SW'(FIFO_DEPTH);

  // Returning data bypasses the empty buffer so the first record appears as it leaves the RAM.
  assign in_valid   = infl_q[1] && (state_q == S_STREAM || state_q == S_DRAIN);
  assign fifo_empty = (occ_q == '0);
  assign incoming   = {tag1_idx_q, tag1_last_q, mem_q};
  assign out_entry  = fifo_empty ? incoming : fifo_mem_q[rp_q];
  assign {entry_idx, entry_last, out_data} = out_entry;

  assign out_valid = in_valid || !fifo_empty;
  assign out_index = out_valid ? entry_idx : '0;
  assign out_last  = out_valid && entry_last;
  assign pop       = out_valid && out_ready;
  assign store     = in_valid && !(fifo_empty && pop);
  assign deq       = pop && !fifo_empty;

  assign busy           = (state_q == S_CNT_WAIT) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done           = (state_q == S_FIN);
  assign particle_count = count_q;
  assign mem_address    = addr_q;
  assign mem_rden       = rden_q;
  assign mem_wren       = 1'b0;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    rden_d      = 1'b0;
    last_d      = last_q;
    last_sent_d = last_sent_q | (pop && out_last);
`ifdef POS_STREAM_COUNT_CLAMP_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CNT_WAIT;
          addr_d      = '0;
          rden_d      = 1'b1;
          last_d      = 1'b0;
          last_sent_d = 1'b0;
        end
      end
      S_CNT_WAIT: begin
        // Address 1 is requested on the count-return edge itself to shorten start-to-first-record.
        if (infl_q[1]) begin
          count_d = new_count;
`ifdef POS_STREAM_COUNT_CLAMP_EN
          if (count_over) err_d = 1'b1;
`endif
          if (new_count == '0) begin
            state_d = S_FIN;
          end else begin
            rden_d   = 1'b1;
            addr_d   = ONE;
            last_d   = (new_count == ONE);
            rd_ptr_d = ONE + ONE;
            state_d  = (new_count == ONE) ? S_DRAIN : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (can_issue) begin
          rden_d   = 1'b1;
          addr_d   = rd_ptr_q;
          last_d   = (rd_ptr_q == count_q);
          rd_ptr_d = rd_ptr_q + ONE;
          if (rd_ptr_q == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_sent_q && !rden_q && infl_q == '0 && fifo_empty) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({store, deq})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      rden_q      <= 1'b0;
      last_q      <= 1'b0;
      last_sent_q <= 1'b0;
      infl_q      <= '0;
      tag0_idx_q  <= '0;
      tag1_idx_q  <= '0;
      tag0_last_q <= 1'b0;
      tag1_last_q <= 1'b0;
      occ_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
`ifdef POS_STREAM_COUNT_CLAMP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      rden_q      <= rden_d;
      last_q      <= last_d;
      last_sent_q <= last_sent_d;
      infl_q      <= {infl_q[0], rden_q};
      tag0_idx_q  <= addr_q;
      tag0_last_q <= last_q;
      tag1_idx_q  <= tag0_idx_q;
      tag1_last_q <= tag0_last_q;
      occ_q       <= occ_d;
      if (store) wp_q <= wp_q + PW'(1);
      if (deq)   rp_q <= rp_q + PW'(1);
`ifdef POS_STREAM_COUNT_CLAMP_EN
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (store) fifo_mem_q[wp_q] <= incoming;
  end

endmodule

// File: tb/tb_pos_cell_stream_reader.sv
// Scoreboard bench for pos_cell_stream_reader: a RAM model answers reads, stimulus queues expected records.
module tb_pos_cell_stream_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          last;
    logic [DW-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, count_err, mem_rden, mem_wren, out_valid, out_last;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic [DW-1:0] mem_q, out_data, rd1;
  logic [DW-1:0] mem [256];

  rec_t exp_q[$];
  int unsigned checks = 0, errors = 0;
  int unsigned issued = 0, xfers = 0, scan_xfers = 0, done_cnt = 0, cyc = 0;
  int unsigned first_xfer_cyc = 0, last_xfer_cyc = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  pos_cell_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .count_err(count_err),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  // RAM with 2-cycle read latency; garbage when no read was issued.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd1   <= mem_rden ? mem[mem_address] : {$urandom, $urandom, $urandom};
    mem_q <= rd1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    rec_t exp;
    logic [AW+DW:0] held;
    logic stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        issued = 0; xfers = 0; stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_payload", {out_index, out_last, out_data}, held);
        end
        if (mem_rden && mem_address != '0) begin
          issued++;
          check("credit_bound", (issued - xfers) <= FD, 1'b1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_transfer actual_index=%0d expected=none", out_index);
          end else begin
            exp = exp_q.pop_front();
            check("out_index", out_index, exp.idx);
            check("out_last", out_last, exp.last);
            check("out_data", out_data, exp.data);
          end
          if (scan_xfers == 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
          scan_xfers++;
          xfers++;
        end
        stalled = out_valid && !out_ready;
        held = {out_index, out_last, out_data};
        if (done) done_cnt++;
      end
    end
  end

  function automatic logic rdy(input int unsigned mode, input int unsigned n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Loads the RAM and queues the records the scan must produce.
  task automatic load_scan(input logic [AW-1:0] cw, input bit fixed, output int unsigned ec);
    logic [DW-1:0] w;
    w = {$urandom, $urandom, $urandom};
    w[AW-1:0] = cw;
    mem[0] = w;
    for (int i = 1; i < 256; i++)
      mem[i] = fixed ? DW'(32'hA0 + i) : {$urandom, $urandom, $urandom};
    ec = int'(cw);
`ifdef POS_STREAM_COUNT_CLAMP_EN
    if (ec > PN - 1) begin
      ec = PN - 1;
      exp_err = 1'b1;
    end
`endif
    for (int i = 1; i <= int'(ec); i++)
      exp_q.push_back('{idx: AW'(i), last: (i == int'(ec)), data: mem[i]});
    done_cnt = 0;
    scan_xfers = 0;
  endtask

  task automatic run_scan(input logic [AW-1:0] cw, input int unsigned mode, input bit fixed);
    int unsigned ec, n, first_valid_n, done_n;
    load_scan(cw, fixed, ec);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1; first_valid_n = 0; done_n = 0;
    while (done_n == 0 && n < 3000) begin
      out_ready = rdy(mode, n);
      start = (mode == 1 && n == 8);
      if (out_valid && first_valid_n == 0) first_valid_n = n;
      if (done) done_n = n;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("done_seen", done_n != 0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_at_done_ignored", busy, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("single_done", done_cnt, 1);
    check("all_records_out", exp_q.size(), 0);
    check("transfer_count", scan_xfers, ec);
    check("busy_after", busy, 1'b0);
    check("particle_count", particle_count, ec);
    check("count_err", count_err, exp_err);
    if (ec == 0) begin
      check("zero_done_latency", done_n, 4);
      check("zero_no_valid", first_valid_n, 0);
    end else begin
      check("first_valid_latency", first_valid_n, 6);
      if (mode == 0) check("throughput_span", last_xfer_cyc - first_xfer_cyc, ec - 1);
    end
  endtask

  task automatic abort_scan();
    int unsigned ec;
    load_scan(AW'(20), 1'b0, ec);
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", out_valid, 1'b0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", particle_count, 0);
    check("rst_count_err", count_err, 1'b0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_rden", mem_rden, 1'b0);
    check("rst_mem_wren", mem_wren, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    run_scan(AW'(3), 0, 1'b1);
    run_scan(AW'(0), 0, 1'b0);
    run_scan(AW'(10), 1, 1'b0);
    run_scan(AW'(219), 0, 1'b0);
    abort_scan();
    run_scan(AW'(2), 0, 1'b0);
    for (int k = 0; k < 3; k++) run_scan(AW'($urandom_range(1, 40)), 2, 1'b0);
    run_scan(AW'(250), 0, 1'b0);
    run_scan(AW'(5), 2, 1'b0);
    check("wren_low", mem_wren, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_cell_stream_reader.md
Name: pos_cell_stream_reader

Overview:
- Read-side sequencer that sits directly upstream of the per-cell position RAM (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz,posy,posx}).
- On a start pulse it fetches the count, then streams every particle record out through a valid/ready interface to the position cache / force-evaluation front end.
- Issues reads credit-based into a small output FIFO, so backpressure never loses RAM data in flight.

Parameters:
- DATA_WIDTH, 96, width of one RAM word ({posz,posy,posx}, 32 bits each).
- ADDR_WIDTH, 8, RAM address width.
- PARTICLE_NUM, 220, RAM depth; the largest legal count is PARTICLE_NUM-1.
- FIFO_DEPTH, 4, output buffer entries; must be at least 3, and is a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a cell scan; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted
- done  out  1  one-cycle pulse when the scan completes
- particle_count  out  ADDR_WIDTH  count latched from address 0; valid while busy and after done
- count_err  out  1  sticky clamp flag (see Optional Feature)
- mem_address  out  ADDR_WIDTH  RAM address
- mem_rden  out  1  RAM read enable
- mem_wren  out  1  held constant 0
- mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the rden cycle
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_WIDTH  particle record
- out_index  out  ADDR_WIDTH  RAM address of the record, 1..count
- out_last  out  1  high with the record whose out_index equals count

Behaviour:
- Reset values: busy=0, done=0, particle_count=0, count_err=0, mem_address=0, mem_rden=0, mem_wren=0, out_valid=0, out_index=0, out_last=0. out_data is don't-care.
- Reset also:
  - forces the state to IDLE and empties the FIFO;
  - clears the 2-stage in-flight valid shift register, so any RAM data returning after reset is discarded.
- Handshake: a transfer occurs when out_valid and out_ready are both high. out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: on start, set busy, drive mem_address=0, mem_rden=1, go to CNT_WAIT.
  - CNT_WAIT: wait 2 cycles. On the return, latch particle_count = mem_q[ADDR_WIDTH-1:0]. If the count is 0, go to FIN; otherwise go to STREAM with rd_ptr=1.
  - STREAM: each cycle, issue a read (mem_rden=1, mem_address=rd_ptr, rd_ptr++) only if fifo_occupancy + inflight < FIFO_DEPTH. The cycle after issuing rd_ptr==count, stop issuing and go to DRAIN.
  - DRAIN: remain until inflight=0, the FIFO is empty, and the final transfer (out_last) has happened; then go to FIN.
  - FIN: for one cycle, done=1 and busy=0; then return to IDLE.
- Throughput: with out_ready held at 1, one record per cycle after a fill latency.
- Latency: the first out_valid appears 2 cycles after the first STREAM read is issued, i.e. at most 6 cycles after start.
- Data ordering: FIFO entries carry {index, last, data}, with last computed at issue as (rd_ptr==count). Output order is strictly 1..count.
- mem_rden is 0 in every cycle in which no read is issued; mem_address holds its last value.
- A FIFO write and a read in the same cycle at full or empty occupancy are legal; the occupancy counter nets to no change.
- A start pulse arriving in the same cycle as done is ignored. A new scan needs a start in IDLE.

Optional Feature:
- Macro: POS_STREAM_COUNT_CLAMP_EN.
- Defined: if the fetched count is greater than PARTICLE_NUM-1, clamp particle_count to PARTICLE_NUM-1 and set count_err=1. count_err stays set until rst.
- Undefined: the count is used raw (its low ADDR_WIDTH bits) and count_err is tied to 0.

Test Plan:
- Count=3 at address 0, records 0xA1/0xA2/0xA3, out_ready=1 -> exactly 3 transfers with out_index 1,2,3; out_last only on index 3; a single done pulse; busy low afterwards.
- Count=0 -> no out_valid; done pulses 4 cycles after start; particle_count=0.
- Count=10, out_ready toggling 1,0,0,1 repeating -> all 10 records in order with no duplicates or drops; mem_rden never issued while occupancy+inflight=FIFO_DEPTH.
- Count=219 with out_ready=1 -> 219 transfers at 1 per cycle after the first; out_last at index 219.
- rst asserted mid-STREAM with 2 reads in flight -> next cycle busy=0, out_valid=0; late mem_q data never appears on the output; a subsequent scan of count=2 completes correctly.
- POS_STREAM_COUNT_CLAMP_EN defined, count word=250 -> particle_count=219, count_err=1, 219 transfers. Macro undefined, same stimulus -> particle_count=250, count_err=0.
